// File: rtl/xgs_spi_access_arbiter.sv
// Round-robin arbiter sharing one XGS sensor SPI master among NREQ requesters.
// It allows one transaction in flight, lets only HP_IDX issue during blackout, and aborts a transaction on a watchdog timeout.
module xgs_spi_access_arbiter #(
  parameter int NREQ    = 3,
  parameter int AW      = 15,
  parameter int DW      = 16,
  parameter int TIMEOUT = 4095,
  parameter int HP_IDX  = 0
) (
  input  logic               sys_clk,
  input  logic               sys_reset_n,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ-1:0]    req_rnw,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]    gnt,
  output logic [NREQ-1:0]    ack,
  output logic [DW-1:0]      rdata,
  output logic               timeout_err,
  input  logic               blackout,
  output logic               spi_start,
  output logic               spi_rnw,
  output logic [AW-1:0]      spi_addr,
  output logic [DW-1:0]      spi_wdata,
  input  logic               spi_busy,
  input  logic               spi_done,
  input  logic [DW-1:0]      spi_rdata
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [NREQ-1:0] HP_MASK = NREQ'(1) << HP_IDX;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_e;

  state_e            state_q, state_d;
  logic [IW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]     owner_q, owner_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [DW-1:0]     rdata_q, rdata_d;
  logic [NREQ-1:0]   ack_q, ack_d;
  logic              terr_q, terr_d;
  logic              start_q, start_d;
  logic              rnw_q, rnw_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [DW-1:0]     wdata_q, wdata_d;

  logic [NREQ-1:0]   elig;
  logic [IW-1:0]     winner;
  logic              found;
  int                scan_idx;

  // The scan starts one past the last owner, so the most recent owner has the lowest priority.
  always_comb begin
    elig     = req & ~({NREQ{blackout}} & ~HP_MASK);
    winner   = '0;
    found    = 1'b0;
    scan_idx = 0;
    for (int k = 1; k <= NREQ; k++) begin
      scan_idx = (int'(rr_ptr_q) + k) % NREQ;
      if (!found && elig[scan_idx]) begin
        winner = IW'(scan_idx);
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    // NOTE: every signal gets a default before the case so no path can infer a latch.
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    timer_d  = timer_q;
    rdata_d  = rdata_q;
    rnw_d    = rnw_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    ack_d    = '0;
    terr_d   = 1'b0;
    start_d  = 1'b0;
    gnt      = '0;
    unique case (state_q)
      IDLE: begin
        if (found && !spi_busy) begin
          gnt     = NREQ'(1) << winner;
          rnw_d   = req_rnw[winner];
          addr_d  = req_addr[int'(winner)*AW +: AW];
          wdata_d = req_wdata[int'(winner)*DW +: DW];
          owner_d = winner;
          start_d = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        // The timer holds the number of cycles elapsed since spi_start was high.
        timer_d = TW'(1);
        state_d = WAIT;
      end
      WAIT: begin
        timer_d = timer_q + TW'(1);
        if (spi_done) begin
          rdata_d = spi_rdata;
          ack_d   = NREQ'(1) << owner_q;
          state_d = ACK;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          rdata_d = '0;
          ack_d   = NREQ'(1) << owner_q;
          terr_d  = 1'b1;
          state_d = ACK;
        end
      end
      ACK: begin
        rr_ptr_d = owner_q;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge sys_clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      state_q  <= IDLE;
      rr_ptr_q <= IW'(NREQ - 1);
      owner_q  <= '0;
      timer_q  <= '0;
      rdata_q  <= '0;
      ack_q    <= '0;
      terr_q   <= 1'b0;
      start_q  <= 1'b0;
      rnw_q    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      timer_q  <= timer_d;
      rdata_q  <= rdata_d;
      ack_q    <= ack_d;
      terr_q   <= terr_d;
      start_q  <= start_d;
      rnw_q    <= rnw_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
    end
  end

  assign ack         = ack_q;
  assign rdata       = rdata_q;
  assign timeout_err = terr_q;
  assign spi_start   = start_q;
  assign spi_rnw     = rnw_q;
  assign spi_addr    = addr_q;
  assign spi_wdata   = wdata_q;

endmodule

// File: tb/tb_xgs_spi_access_arbiter.sv
// Self-checking bench for xgs_spi_access_arbiter. A cycle-timeline reference model predicts grants, SPI commands, acks and timeouts.
module tb_xgs_spi_access_arbiter;

  localparam int NREQ = 3, AW = 15, DW = 16, TIMEOUT = 24, HP_IDX = 0;

  logic               sys_clk = 1'b0;
  logic               sys_reset_n = 1'b0;
  logic [NREQ-1:0]    req = '0, req_rnw = '0;
  logic [NREQ*AW-1:0] req_addr = '0;
  logic [NREQ*DW-1:0] req_wdata = '0;
  logic [NREQ-1:0]    gnt, ack;
  logic [DW-1:0]      rdata;
  logic               timeout_err;
  logic               blackout = 1'b0;
  logic               spi_start, spi_rnw;
  logic [AW-1:0]      spi_addr;
  logic [DW-1:0]      spi_wdata;
  logic               spi_busy = 1'b0, spi_done = 1'b0;
  logic [DW-1:0]      spi_rdata = '0;

  xgs_spi_access_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .TIMEOUT(TIMEOUT), .HP_IDX(HP_IDX)) dut (
    .sys_clk(sys_clk), .sys_reset_n(sys_reset_n), .req(req), .req_rnw(req_rnw),
    .req_addr(req_addr), .req_wdata(req_wdata), .gnt(gnt), .ack(ack), .rdata(rdata),
    .timeout_err(timeout_err), .blackout(blackout), .spi_start(spi_start),
    .spi_rnw(spi_rnw), .spi_addr(spi_addr), .spi_wdata(spi_wdata),
    .spi_busy(spi_busy), .spi_done(spi_done), .spi_rdata(spi_rdata));

  always #5 sys_clk = ~sys_clk;

  int n_checks = 0, n_fail = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Requester commands waiting for a grant
  bit            pending [NREQ];
  bit            p_rnw   [NREQ];
  logic [AW-1:0] p_addr  [NREQ];
  logic [DW-1:0] p_wdata [NREQ];

  // Timeline of the transaction in flight, expressed as absolute cycle numbers
  int            cyc = 0;
  bit            in_flight;
  int            owner_m, last_m;
  int            start_cyc, done_cyc, ack_cyc;
  bit            exp_err;
  logic [DW-1:0] exp_rdata;
  logic          lat_rnw;
  logic [AW-1:0] lat_addr;
  logic [DW-1:0] lat_wdata;

  // Stimulus knobs
  logic [NREQ-1:0] auto_mask = '0;
  int              req_pct = 0, busy_pct = 0, bo_mode = 0, delay_mode = 0;
  bit              force_rd = 0;
  logic [DW-1:0]   force_rd_val = '0;

  // What the DUT was observed doing
  logic [NREQ-1:0] gnt_log [$];
  int              ack_count = 0, last_gnt_cyc = -1, last_start_cyc = -1, last_ack_cyc = -1;
  logic [DW-1:0]   last_rdata;
  logic            last_err;

  task automatic new_cmd(input int i);
    pending[i] = 1'b1;
    p_rnw[i]   = $urandom_range(1);
    p_addr[i]  = AW'($urandom);
    p_wdata[i] = DW'($urandom);
  endtask

  function automatic int pick_delay();
    int r;
    if (delay_mode > 0) return delay_mode;
    if (delay_mode < 0) return 0;
    r = $urandom_range(99);
    if (r < 10) return 0;
    if (r < 20) return TIMEOUT - 1;
    return $urandom_range(TIMEOUT - 1, 1);
  endfunction

  task automatic reset_model();
    for (int i = 0; i < NREQ; i++) pending[i] = 1'b0;
    in_flight = 1'b0;
    last_m    = NREQ - 1;
    lat_rnw   = 1'b0;
    lat_addr  = '0;
    lat_wdata = '0;
  endtask

  // One clock cycle: drive at +2, sample at +4, then advance to the next rising edge.
  task automatic step();
    logic [NREQ-1:0] elig, exp_gnt, exp_ack;
    int win, idx, d;
    #2;
    for (int i = 0; i < NREQ; i++) begin
      req[i]                 = pending[i];
      req_rnw[i]             = p_rnw[i];
      req_addr[i*AW +: AW]   = p_addr[i];
      req_wdata[i*DW +: DW]  = p_wdata[i];
    end
    if (bo_mode == 2) begin
      if ($urandom_range(99) < 8) blackout = ~blackout;
    end else begin
      blackout = (bo_mode == 1);
    end
    spi_busy  = ($urandom_range(99) < busy_pct);
    spi_rdata = force_rd ? force_rd_val : DW'($urandom);
    if (in_flight && cyc == done_cyc)
      spi_done = 1'b1;
    else if (!in_flight || cyc == start_cyc || cyc == ack_cyc)
      spi_done = ($urandom_range(99) < 10);
    else
      spi_done = 1'b0;
    #2;
    exp_gnt = '0;
    win = -1;
    for (int i = 0; i < NREQ; i++) elig[i] = pending[i] && (!blackout || i == HP_IDX);
    if (!in_flight && !spi_busy) begin
      for (int k = 1; k <= NREQ; k++) begin
        idx = (last_m + k) % NREQ;
        if (win < 0 && elig[idx]) win = idx;
      end
    end
    if (win >= 0) exp_gnt[win] = 1'b1;
    exp_ack = (in_flight && cyc == ack_cyc) ? NREQ'(1) << owner_m : '0;
    if (in_flight && cyc == done_cyc) exp_rdata = spi_rdata;

    check("gnt", gnt, exp_gnt);
    check("ack", ack, exp_ack);
    check("timeout_err", timeout_err, (exp_ack != 0) && exp_err);
    check("spi_start", spi_start, in_flight && cyc == start_cyc);
    check("spi_rnw", spi_rnw, lat_rnw);
    check("spi_addr", spi_addr, lat_addr);
    check("spi_wdata", spi_wdata, lat_wdata);
    if (exp_ack != 0) check("rdata", rdata, exp_rdata);

    if (gnt != 0) begin gnt_log.push_back(gnt); last_gnt_cyc = cyc; end
    if (spi_start) last_start_cyc = cyc;
    if (ack != 0) begin
      ack_count++;
      last_ack_cyc = cyc;
      last_rdata   = rdata;
      last_err     = timeout_err;
    end

    if (exp_ack != 0) begin
      in_flight = 1'b0;
      last_m    = owner_m;
    end
    if (win >= 0) begin
      in_flight  = 1'b1;
      owner_m    = win;
      start_cyc  = cyc + 1;
      lat_rnw    = p_rnw[win];
      lat_addr   = p_addr[win];
      lat_wdata  = p_wdata[win];
      pending[win] = 1'b0;
      d = pick_delay();
      if (d > 0) begin
        done_cyc = start_cyc + d;
        ack_cyc  = done_cyc + 1;
        exp_err  = 1'b0;
      end else begin
        done_cyc  = -1;
        ack_cyc   = start_cyc + TIMEOUT;
        exp_err   = 1'b1;
        exp_rdata = '0;
      end
    end
    for (int i = 0; i < NREQ; i++)
      if (auto_mask[i] && !pending[i] && i != win && $urandom_range(99) < req_pct) new_cmd(i);
    @(posedge sys_clk);
    cyc++;
  endtask

  task automatic apply_reset();
    #3;
    sys_reset_n = 1'b0;
    req = '0; spi_done = 1'b0; spi_busy = 1'b0; blackout = 1'b0;
    #1;
    check("rst_gnt", gnt, 0);
    check("rst_ack", ack, 0);
    check("rst_rdata", rdata, 0);
    check("rst_timeout_err", timeout_err, 0);
    check("rst_spi_start", spi_start, 0);
    check("rst_spi_rnw", spi_rnw, 0);
    check("rst_spi_addr", spi_addr, 0);
    check("rst_spi_wdata", spi_wdata, 0);
    reset_model();
    repeat (2) @(posedge sys_clk);
    #3 sys_reset_n = 1'b1;
    @(posedge sys_clk);
    cyc++;
  endtask

  task automatic run_until_gnts(input int n, input string tag);
    int budget = 8 * n * (TIMEOUT + 6);
    while (gnt_log.size() < n && budget > 0) begin step(); budget--; end
    check(tag, gnt_log.size() >= n, 1);
  endtask

  task automatic run_until_acks(input int n, input string tag);
    int budget = 4 * (TIMEOUT + 6);
    while (ack_count < n && budget > 0) begin step(); budget--; end
    check(tag, ack_count >= n, 1);
  endtask

  task automatic run_until_idle();
    int budget = 40 * (TIMEOUT + 6);
    while ((in_flight || pending[0] || pending[1] || pending[2]) && budget > 0) begin
      step();
      budget--;
    end
    check("idle_budget", in_flight, 0);
  endtask

  initial begin
    reset_model();
    @(posedge sys_clk);
    apply_reset();

    // Test 1: single write from requester 1, spi_done arrives 20 cycles after spi_start
    pending[1] = 1'b1; p_rnw[1] = 1'b0; p_addr[1] = 15'h3800; p_wdata[1] = 16'h0001;
    delay_mode = 20;
    gnt_log.delete();
    ack_count = 0;
    run_until_acks(1, "t1_ack_budget");
    check("t1_gnt", gnt_log.size() > 0 ? gnt_log[0] : '0, 3'b010);
    check("t1_start_lat", last_start_cyc - last_gnt_cyc, 1);
    check("t1_ack_lat", last_ack_cyc - last_start_cyc, 21);
    repeat (2) step();

    // Test 2: all three requesters held high continuously from reset
    apply_reset();
    delay_mode = 0; auto_mask = '1; req_pct = 100;
    for (int i = 0; i < NREQ; i++) new_cmd(i);
    gnt_log.delete();
    run_until_gnts(6, "t2_gnt_budget");
    for (int i = 0; i < 6; i++)
      check($sformatf("t2_order_%0d", i), gnt_log.size() > i ? gnt_log[i] : '0, NREQ'(1) << (i % NREQ));
    auto_mask = '0; req_pct = 0;
    run_until_idle();

    // Test 3: blackout admits only the high-priority requester
    bo_mode = 1;
    new_cmd(1); new_cmd(2);
    gnt_log.delete();
    repeat (10) step();
    check("t3_blocked", gnt_log.size(), 0);
    new_cmd(0);
    run_until_gnts(1, "t3_hp_budget");
    check("t3_hp_gnt", gnt_log.size() > 0 ? gnt_log[0] : '0, 3'b001);
    bo_mode = 0;
    run_until_gnts(3, "t3_release_budget");
    check("t3_gnt1", gnt_log.size() > 1 ? gnt_log[1] : '0, 3'b010);
    check("t3_gnt2", gnt_log.size() > 2 ? gnt_log[2] : '0, 3'b100);
    run_until_idle();

    // Test 4: read returns SPI data on ack without error
    force_rd = 1; force_rd_val = 16'hA5C3; delay_mode = 5;
    new_cmd(2); p_rnw[2] = 1'b1;
    ack_count = 0;
    run_until_acks(1, "t4_ack_budget");
    check("t4_rdata", last_rdata, 16'hA5C3);
    check("t4_err", last_err, 0);
    force_rd = 0;

    // Test 5: watchdog abort, then done exactly on the last allowed cycle, then normal service
    delay_mode = -1;
    new_cmd(1);
    ack_count = 0;
    run_until_acks(1, "t5_ack_budget");
    check("t5_err", last_err, 1);
    check("t5_rdata", last_rdata, 0);
    check("t5_ack_lat", last_ack_cyc - last_start_cyc, TIMEOUT);
    delay_mode = TIMEOUT - 1;
    new_cmd(0);
    ack_count = 0;
    run_until_acks(1, "t5b_ack_budget");
    check("t5b_err", last_err, 0);
    check("t5b_ack_lat", last_ack_cyc - last_start_cyc, TIMEOUT);
    delay_mode = 3;
    new_cmd(2);
    ack_count = 0;
    run_until_acks(1, "t5c_ack_budget");
    check("t5c_err", last_err, 0);

    // Test 6: reset asserted mid-WAIT, then requesters 2 and 0 compete
    delay_mode = 15;
    new_cmd(1);
    begin
      int budget = 20;
      while (!(in_flight && cyc == start_cyc + 3) && budget > 0) begin step(); budget--; end
      check("t6_wait_budget", in_flight, 1);
    end
    apply_reset();
    delay_mode = 4;
    new_cmd(2); new_cmd(0);
    gnt_log.delete();
    run_until_gnts(2, "t6_gnt_budget");
    check("t6_first", gnt_log.size() > 0 ? gnt_log[0] : '0, 3'b001);
    check("t6_second", gnt_log.size() > 1 ? gnt_log[1] : '0, 3'b100);
    run_until_idle();

    // Random soak: random requests, SPI busy, blackout phases, done delays and timeouts
    auto_mask = '1; req_pct = 30; busy_pct = 15; bo_mode = 2; delay_mode = 0;
    repeat (3000) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
